sklansky_subtractor_pipe: RTL and testbench

//   Pipelined Sklansky prefix subtractor: computes diff = a - b as a + ~b + 1. Carry-in 1 feeds the
//   bit-0 gray cell. Inverse companion to the registered Sklansky adder; same g/p, black and gray cells.
//   Two register stages with a valid/ready handshake on both sides. Sits between the operand

---
 rtl/sklansky_subtractor_pipe_if.sv | 28 ++
 rtl/sklansky_subtractor_pipe.sv | 130 +++++++++++++
 tb/tb_sklansky_subtractor_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sklansky_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined Sklansky subtractor.
interface sklansky_subtractor_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             neg;
  logic             ovf;

  // Subtractor side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero, neg, ovf
  );

  // Operand source / result sink side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, neg, ovf
  );
endinterface

// File: rtl/sklansky_subtractor_pipe.sv
// Two-stage Sklansky prefix subtractor: diff = a + ~b + 1.
// The carry-in is folded in as an extra prefix position 0 (g=1, p=0), so
// position j of the prefix tree carries the group term for bits j-1..-1.
// Stage 1 evaluates the first ceil(L/2) prefix levels, stage 2 the rest.
module sklansky_subtractor_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  sklansky_subtractor_pipe_if.slave   bus
);
  localparam int N  = WIDTH + 1;          // prefix positions incl. carry-in
  localparam int L  = $clog2(WIDTH) + 1;  // prefix depth
  localparam int S1 = (L + 1) / 2;        // levels resolved in stage 1
  localparam int NB = $clog2(N);

  logic [2:1]       r_vld_pipe;           // [1] stage-1 valid, [2] out_valid
  logic [N-1:0]     r_g1, r_p1;
  logic [WIDTH-1:0] r_praw;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow, r_zero, r_neg, r_ovf;

  logic [N-1:0]     w_g1, w_p1, w_gt1, w_pt1;
  logic [N-1:0]     w_g2, w_p2, w_gt2, w_pt2;
  logic [WIDTH-1:0] w_diff;
  logic             w_s2_free, w_s1_free, w_in_ready;
  logic             w_accept, w_s1_move, w_out_fire;

  // Handshake: in_ready never looks at in_valid; enable gates every advance.
  assign w_s2_free  = !r_vld_pipe[2] || bus.out_ready;
  assign w_s1_free  = !r_vld_pipe[1] || w_s2_free;
  assign w_in_ready = enable && reset_n && w_s1_free;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_s1_move  = enable && r_vld_pipe[1] && w_s2_free;
  assign w_out_fire = enable && r_vld_pipe[2] && bus.out_ready;

  // Stage-1 prefix levels 0..S1-1 on a + ~b with carry-in at position 0.
  always_comb begin
    w_g1  = {bus.a & ~bus.b, 1'b1};
    w_p1  = {bus.a ^ ~bus.b, 1'b0};
    w_gt1 = w_g1;
    w_pt1 = w_p1;
    for (int lv = 0; lv < S1; lv++) begin
      w_gt1 = w_g1;
      w_pt1 = w_p1;
      for (int j = 0; j < N; j++) begin
        if (((j >> lv) & 1) == 1) begin
          w_gt1[j] = w_g1[j] | (w_p1[j] & w_g1[NB'(((j >> lv) << lv) - 1)]);
          w_pt1[j] = w_p1[j] & w_p1[NB'(((j >> lv) << lv) - 1)];
        end
      end
      w_g1 = w_gt1;
      w_p1 = w_pt1;
    end
  end

  // Stage-2 prefix levels S1..L-1 finish the carries from the registered terms.
  always_comb begin
    w_g2  = r_g1;
    w_p2  = r_p1;
    w_gt2 = w_g2;
    w_pt2 = w_p2;
    for (int lv = S1; lv < L; lv++) begin
      w_gt2 = w_g2;
      w_pt2 = w_p2;
      for (int j = 0; j < N; j++) begin
        if (((j >> lv) & 1) == 1) begin
          w_gt2[j] = w_g2[j] | (w_p2[j] & w_g2[NB'(((j >> lv) << lv) - 1)]);
          w_pt2[j] = w_p2[j] & w_p2[NB'(((j >> lv) << lv) - 1)];
        end
      end
      w_g2 = w_gt2;
      w_p2 = w_pt2;
    end
  end

  // Position i of the finished tree is the carry into bit i.
  assign w_diff = r_praw ^ w_g2[WIDTH-1:0];

  // Valid tracking; reload wins over drain so a fire+advance keeps valid high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_accept)       r_vld_pipe[1] <= 1'b1;
      else if (w_s1_move) r_vld_pipe[1] <= 1'b0;
      if (w_s1_move)       r_vld_pipe[2] <= 1'b1;
      else if (w_out_fire) r_vld_pipe[2] <= 1'b0;
    end
  end

  // Stage-1 data: partial group terms plus raw propagate for the sum XOR.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_g1   <= '0;
      r_p1   <= '0;
      r_praw <= '0;
    end else if (w_accept) begin
      r_g1   <= w_g1;
      r_p1   <= w_p1;
      r_praw <= bus.a ^ ~bus.b;
    end
  end

  // Stage-2 result and flags; overflow is carry-into-MSB xor carry-out.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_s1_move) begin
      r_diff   <= w_diff;
      r_borrow <= ~w_g2[WIDTH];
      r_zero   <= ~|w_diff;
      r_neg    <= w_diff[WIDTH-1];
      r_ovf    <= w_g2[WIDTH-1] ^ w_g2[WIDTH];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_pipe[2];
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_sklansky_subtractor_pipe.sv
// Bench for sklansky_subtractor_pipe: directed vector table, random streamed
// traffic with backpressure against an arithmetic model, and hold/reset.
module tb_sklansky_subtractor_pipe;
  localparam int W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic enable  = 1'b1;

  sklansky_subtractor_pipe_if #(.WIDTH(W)) bus();

  sklansky_subtractor_pipe #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow, zero, neg, ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a, b;
    res_t         exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain modular and signed integer arithmetic.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int   sd;
    r.diff   = a - b;
    r.borrow = (a < b);
    r.zero   = (a == b);
    r.neg    = r.diff[W-1];
    sd       = int'($signed(a)) - int'($signed(b));
    r.ovf    = (sd > 127) || (sd < -128);
    return r;
  endfunction

  function automatic logic [31:0] pack_dut();
    return {20'd0, bus.diff, bus.borrow, bus.zero, bus.neg, bus.ovf};
  endfunction

  function automatic logic [31:0] pack_res(input res_t r);
    return {20'd0, r.diff, r.borrow, r.zero, r.neg, r.ovf};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t         vt[8];
  logic [W-1:0] sa[10], sb[10];
  res_t         q[$];
  res_t         e;
  int           idx, got_n;
  logic [W-1:0] prev_diff;
  logic         acc, fire;

  initial begin
    //                a      b       diff   brw zero neg ovf
    vt[0] = '{8'd200, 8'd55,  '{8'd145, 1'b0, 1'b0, 1'b1, 1'b0}};
    vt[1] = '{8'd3,   8'd5,   '{8'hFE,  1'b1, 1'b0, 1'b1, 1'b0}};
    vt[2] = '{8'h80,  8'h01,  '{8'h7F,  1'b0, 1'b0, 1'b0, 1'b1}};
    vt[3] = '{8'h7F,  8'hFF,  '{8'h80,  1'b1, 1'b0, 1'b1, 1'b1}};
    vt[4] = '{8'h5A,  8'h5A,  '{8'h00,  1'b0, 1'b1, 1'b0, 1'b0}};
    vt[5] = '{8'hFF,  8'h00,  '{8'hFF,  1'b0, 1'b0, 1'b1, 1'b0}};
    vt[6] = '{8'h00,  8'hFF,  '{8'h01,  1'b1, 1'b0, 1'b0, 1'b0}};
    vt[7] = '{8'h00,  8'h80,  '{8'h80,  1'b1, 1'b0, 1'b1, 1'b1}};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", pack_dut(), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed table, one operand pair at a time
    for (int i = 0; i < 8; i++) begin
      bus.a        = vt[i].a;
      bus.b        = vt[i].b;
      bus.in_valid = 1'b1;
      #1;
      check("tbl_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("tbl_lat1_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
      check("tbl_lat2_valid", {31'd0, bus.out_valid}, 32'd1);
      check("tbl_result", pack_dut(), pack_res(vt[i].exp));
      tick();
      check("tbl_drained", {31'd0, bus.out_valid}, 32'd0);
    end

    // Random stream with out_ready low in cycles 3..6
    for (int i = 0; i < 10; i++) begin
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
    end
    sa[4] = sb[4];
    idx       = 0;
    got_n     = 0;
    prev_diff = bus.diff;
    for (int cyc = 0; cyc < 200 && got_n < 10; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid  = (idx < 10);
      if (idx < 10) begin
        bus.a = sa[idx];
        bus.b = sb[idx];
      end
      #1;
      if (cyc >= 3 && cyc <= 6)
        check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      if (cyc >= 4 && cyc <= 6)
        check("stall_hold_diff", {24'd0, bus.diff}, {24'd0, prev_diff});
      acc  = bus.in_valid && bus.in_ready;
      fire = bus.out_valid && bus.out_ready;
      if (fire) begin
        if (q.size() == 0) begin
          check("stream_spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("stream_result", pack_dut(), pack_res(e));
          got_n++;
        end
      end
      if (acc) begin
        q.push_back(model(bus.a, bus.b));
        idx++;
      end
      prev_diff = bus.diff;
      tick();
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", idx, 32'd10);
    check("stream_results", got_n, 32'd10);
    #1;
    check("stream_no_dup", {31'd0, bus.out_valid}, 32'd0);

    // Fill the pipeline, freeze with enable=0, then reset
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 8'h10; bus.b = 8'h03;
    tick();
    bus.a = 8'h20; bus.b = 8'h01;
    tick();
    bus.a = 8'h33; bus.b = 8'h02;
    #1;
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_result", pack_dut(), pack_res(model(8'h10, 8'h03)));
    end
    enable        = 1'b1;
    reset_n       = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    check("rst2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst2_result", pack_dut(), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst2_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst2_discarded", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
